game_master_fsm_multi_torpedo: RTL
==================================

// Module: game_master_fsm_multi_torpedo
// PURPOSE
//  Top-level game sequencer for the target/torpedo game. Generalises the single-shot master to N torpedo slots.
//  Adds a score counter, a lives budget and a game-over state. Sits between the sprite engines (target + N torpedoes),
//  the collision detector, the end-of-game timer and the key input.
// PARAMETERS
//  N_TORPEDOES  2  number of torpedo sprites/slots (1..8)
//  LIVES        3  misses allowed before game over (1..15)
//  SCORE_W      8  score counter width; saturates at all-ones
//  AUTOFIRE_PER 16 repeat interval in clk cycles (used only with GAME_MASTER_AUTOFIRE_EN)
// PORTS
//  clk                          in  1    clock
//  reset                        in  1    asynchronous, active-high
//  key                          in  1    fire button, level, already synchronised
//  sprite_target_write_xy       out 1    load target start position
//  sprite_target_write_dxy      out 1    load target velocity
//  sprite_target_enable_update  out 1    target moves
//  sprite_torpedo_write_xy      out N    per-slot load launch position
//  sprite_torpedo_write_dxy     out N    per-slot load launch velocity
//  sprite_torpedo_enable_update out N    per-slot torpedo moves
//  sprite_target_within_screen  in  1    target on screen
//  sprite_torpedo_within_screen in  N    per-slot torpedo on screen
//  collision                    in  N    per-slot torpedo/target hit
//  end_of_game_timer_start      out 1    1-cycle pulse starting round-end timer
//  end_of_game_timer_running    in  1    round-end timer busy
//  game_won                     out 1    high in WON, WON_END
//  game_over                    out 1    high in OVER
//  score                        out SCORE_W  hits so far
//  lives_left                   out clog2(LIVES+1)  remaining lives
// BEHAVIOUR
//  States: START, PLAY, WON, WON_END, LOST, LOST_END, OVER. One-hot register. Outputs decoded from state and slot flags.
//  Reset (async) -> START, all slots idle, score=0, lives_left=LIVES, key_q=0.
//  START: target write_xy/dxy=1, all torpedo write_xy/dxy=1, no update -> PLAY next cycle.
//  PLAY: target_enable_update=1. Torpedo enable_update[i]=flying[i].
//   Fire event = key rising edge (key & ~key_q). It launches the lowest-index idle slot i:
//   write_xy[i]/write_dxy[i] pulse 1 cycle; flying[i] set the next cycle. Fire with all slots flying is ignored.
//   Priority per cycle:
//    1. any collision[i] with flying[i] -> WON, score+1 (sat).
//    2. else ~target_within_screen -> LOST.
//    3. else stay.
//   Flying slot with ~torpedo_within_screen[i] -> flying[i] cleared (slot free), no life lost.
//   collision/out-of-screen on idle slots ignored. Launch and free of same slot in one cycle: free wins, no launch to it.
//  WON: timer_start=1 -> WON_END. WON_END: wait ~timer_running -> START (slots cleared).
//  LOST: timer_start=1, lives_left-1 -> LOST_END. LOST_END: wait ~timer_running -> lives_left==0 ? OVER : START.
//  OVER: all enables 0; fire event -> score=0, lives_left=LIVES, START.
//  Illegal state -> START (recovery, no X).
//  score/lives_left registered; visible the cycle after the WON/LOST entry.
// CONFIGURATION
//  GAME_MASTER_AUTOFIRE_EN defined: in PLAY, key held generates a fire event every AUTOFIRE_PER cycles
//   after the rising edge (counter resets on key release or state exit).
//  Undefined: only rising edges fire; the counter is not built.
// STRUCTURE
//  game_config.vh: state encodings, default GAME_MASTER_AUTOFIRE_EN setting, slot-count limits.
//  Sub-module game_torpedo_slot_alloc: flying[N] flags, lowest-idle priority encoder, launch pulse, free logic.
// TESTING
//  1. reset, release -> START 1 cycle (all write outputs=1), then PLAY; score=0, lives_left=3.
//  2. N=2: three key edges 4 cycles apart, no collision -> write_xy=01, then 10, third ignored; enable_update=11.
//  3. collision=10 with slot1 flying and target off-screen in the same cycle -> WON, score=1, timer_start pulse 1 cycle.
//  4. target off-screen 3 times (timer_running 5 cycles each) -> lives 2,1,0, then OVER; game_over=1; key edge -> START, score=0.
//  5. torpedo0 off-screen -> slot0 freed, next key edge launches slot0 again; lives unchanged.
//  6. AUTOFIRE_EN, AUTOFIRE_PER=16, key held 40 cycles -> launches at t0, t0+16, t0+32 (slot-limited); reset mid-PLAY -> START.

Source files
------------

// File: rtl/game_master_fsm_multi_torpedo_pkg.sv
// -----------------------------------------------------------------------------
// game_master_fsm_multi_torpedo_pkg
// Shared definitions for the multi-torpedo game sequencer:
//   - one-hot state encoding of the top-level game FSM
//   - legal ranges for the slot count and the lives budget
//   - decode of the single-bit control outputs from a state value
// Optional feature used by the importing files: GAME_MASTER_AUTOFIRE_EN.
// -----------------------------------------------------------------------------
package game_master_fsm_multi_torpedo_pkg;

    localparam int MIN_TORPEDOES = 1;
    localparam int MAX_TORPEDOES = 8;
    localparam int MIN_LIVES     = 1;
    localparam int MAX_LIVES     = 15;

    typedef enum logic [6:0] {
        ST_START    = 7'b000_0001,
        ST_PLAY     = 7'b000_0010,
        ST_WON      = 7'b000_0100,
        ST_WON_END  = 7'b000_1000,
        ST_LOST     = 7'b001_0000,
        ST_LOST_END = 7'b010_0000,
        ST_OVER     = 7'b100_0000
    } state_t;

    // Single-bit controls that depend on the game state only.
    typedef struct packed {
        logic tgt_write_xy;
        logic tgt_write_dxy;
        logic tgt_enable;
        logic timer_start;
        logic won;
        logic over;
    } ctrl_t;

    // Decode of the state-only controls; illegal codes give all-zero controls.
    function automatic ctrl_t f_ctrl_decode(input state_t s);
        ctrl_t c;
        c = '{default: 1'b0};
        case (s)
            ST_START: begin
                c.tgt_write_xy  = 1'b1;
                c.tgt_write_dxy = 1'b1;
            end
            ST_PLAY:     c.tgt_enable  = 1'b1;
            ST_WON: begin
                c.timer_start = 1'b1;
                c.won         = 1'b1;
            end
            ST_WON_END:  c.won         = 1'b1;
            ST_LOST:     c.timer_start = 1'b1;
            ST_LOST_END: c.won         = 1'b0;
            ST_OVER:     c.over        = 1'b1;
            default:     c = '{default: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_master_fsm_multi_torpedo_slot_alloc.sv
// -----------------------------------------------------------------------------
// game_master_fsm_multi_torpedo_slot_alloc
// Torpedo slot bookkeeping: per-slot flying flags, lowest-index idle slot
// selection, one-cycle launch pulse and freeing of slots that left the screen.
// A slot with a pending launch pulse counts as busy, and a slot being freed
// this cycle is still busy, so a launch can never land on a slot being freed.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   i_play         game is in PLAY; outside PLAY all slots are cleared
//   i_fire         fire event this cycle
//   i_within       per-slot torpedo on screen
//   o_flying       registered flying flags
//   o_flying_d     flying flags for the next cycle
//   o_launch_d     launch pulse vector for the next cycle
// -----------------------------------------------------------------------------
module game_master_fsm_multi_torpedo_slot_alloc #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_play,
    input  logic         i_fire,
    input  logic [N-1:0] i_within,
    output logic [N-1:0] o_flying,
    output logic [N-1:0] o_flying_d,
    output logic [N-1:0] o_launch_d
);

    logic [N-1:0] r_flying;
    logic [N-1:0] r_launch;
    logic [N-1:0] w_busy;
    logic [N-1:0] w_free;
    logic [N-1:0] w_sel;

    // Lowest idle slot selection and next-cycle slot flags.
    always_comb begin
        w_busy = r_flying | r_launch;
        w_free = r_flying & ~i_within;
        w_sel  = '0;
        // Scan downwards so the last hit is the lowest idle index.
        for (int i = N - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_sel    = '0;
                w_sel[i] = 1'b1;
            end else begin
                w_sel = w_sel;
            end
        end
        if (i_play) begin
            o_flying_d = (r_flying & ~w_free) | r_launch;
            // An all-zero select means every slot is busy: the fire is dropped.
            o_launch_d = i_fire ? w_sel : '0;
        end else begin
            o_flying_d = '0;
            o_launch_d = '0;
        end
    end

    // Slot flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flying <= '0;
            r_launch <= '0;
        end else begin
            r_flying <= o_flying_d;
            r_launch <= o_launch_d;
        end
    end

    assign o_flying = r_flying;

endmodule

// File: rtl/game_master_fsm_multi_torpedo.sv
// -----------------------------------------------------------------------------
// game_master_fsm_multi_torpedo
// Top-level sequencer of the target/torpedo game with N torpedo slots, a
// saturating score counter, a lives budget and a game-over state.
// Optional feature: define GAME_MASTER_AUTOFIRE_EN to make a held key fire
// again every AUTOFIRE_PER cycles while playing (counter not built otherwise).
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   i_key                               fire button (level, synchronised)
//   o_sprite_target_write_xy/dxy        load target start position / velocity
//   o_sprite_target_enable_update       target moves
//   o_sprite_torpedo_write_xy/dxy [N]   per-slot launch position / velocity
//   o_sprite_torpedo_enable_update [N]  per-slot torpedo moves
//   i_sprite_target_within_screen       target on screen
//   i_sprite_torpedo_within_screen [N]  per-slot torpedo on screen
//   i_collision [N]                     per-slot torpedo/target hit
//   o_end_of_game_timer_start           one-cycle round-end timer start
//   i_end_of_game_timer_running         round-end timer busy
//   o_game_won, o_game_over             status flags
//   o_score, o_lives_left               hit count, remaining lives
// All outputs are registers loaded with the decode of the next state.
// -----------------------------------------------------------------------------
module game_master_fsm_multi_torpedo
    import game_master_fsm_multi_torpedo_pkg::*;
#(
    parameter  int N_TORPEDOES  = 2,
    parameter  int LIVES        = 3,
    parameter  int SCORE_W      = 8,
    parameter  int AUTOFIRE_PER = 16,
    localparam int LIVES_W      = $clog2(LIVES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_key,
    output logic                   o_sprite_target_write_xy,
    output logic                   o_sprite_target_write_dxy,
    output logic                   o_sprite_target_enable_update,
    output logic [N_TORPEDOES-1:0] o_sprite_torpedo_write_xy,
    output logic [N_TORPEDOES-1:0] o_sprite_torpedo_write_dxy,
    output logic [N_TORPEDOES-1:0] o_sprite_torpedo_enable_update,
    input  logic                   i_sprite_target_within_screen,
    input  logic [N_TORPEDOES-1:0] i_sprite_torpedo_within_screen,
    input  logic [N_TORPEDOES-1:0] i_collision,
    output logic                   o_end_of_game_timer_start,
    input  logic                   i_end_of_game_timer_running,
    output logic                   o_game_won,
    output logic                   o_game_over,
    output logic [SCORE_W-1:0]     o_score,
    output logic [LIVES_W-1:0]     o_lives_left
);

    // Parameter range guards.
    if (N_TORPEDOES < MIN_TORPEDOES || N_TORPEDOES > MAX_TORPEDOES) begin : g_bad_n
        $error("N_TORPEDOES out of range");
    end
    if (LIVES < MIN_LIVES || LIVES > MAX_LIVES) begin : g_bad_lives
        $error("LIVES out of range");
    end
    if (AUTOFIRE_PER < 1) begin : g_bad_af
        $error("AUTOFIRE_PER must be at least 1");
    end

    state_t                 r_state;
    state_t                 w_state_d;
    logic                   r_key_q;
    logic                   w_key_edge;
    logic                   w_fire;
    logic                   w_hit;
    logic                   w_play;
    logic [SCORE_W-1:0]     r_score;
    logic [LIVES_W-1:0]     r_lives;
    logic [N_TORPEDOES-1:0] w_flying;
    logic [N_TORPEDOES-1:0] w_flying_d;
    logic [N_TORPEDOES-1:0] w_launch_d;
    ctrl_t                  w_ctrl_d;
    logic [N_TORPEDOES-1:0] w_torp_write_d;
    logic [N_TORPEDOES-1:0] w_torp_en_d;

    logic                   r_tgt_write_xy;
    logic                   r_tgt_write_dxy;
    logic                   r_tgt_enable;
    logic [N_TORPEDOES-1:0] r_torp_write;
    logic [N_TORPEDOES-1:0] r_torp_en;
    logic                   r_timer_start;
    logic                   r_won;
    logic                   r_over;

    assign w_play     = (r_state == ST_PLAY);
    assign w_key_edge = i_key & ~r_key_q;
    assign w_hit      = |(i_collision & w_flying);

`ifdef GAME_MASTER_AUTOFIRE_EN
    localparam int AF_W = (AUTOFIRE_PER > 1) ? $clog2(AUTOFIRE_PER) : 1;

    logic [AF_W-1:0] r_af_cnt;
    logic            w_af_tick;

    // Held key in PLAY: tick once the counter has covered a full period.
    assign w_af_tick = w_play & i_key & r_key_q & (r_af_cnt == AF_W'(AUTOFIRE_PER - 1));

    // Autofire period counter; restarts on release, on a new press and outside PLAY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_af_cnt <= '0;
        end else if (!w_play || !i_key || w_key_edge || w_af_tick) begin
            r_af_cnt <= '0;
        end else begin
            r_af_cnt <= r_af_cnt + AF_W'(1);
        end
    end

    assign w_fire = w_key_edge | w_af_tick;
`else
    assign w_fire = w_key_edge;
`endif

    game_master_fsm_multi_torpedo_slot_alloc #(
        .N (N_TORPEDOES)
    ) u_slot_alloc (
        .clk        (clk),
        .reset      (reset),
        .i_play     (w_play),
        .i_fire     (w_fire),
        .i_within   (i_sprite_torpedo_within_screen),
        .o_flying   (w_flying),
        .o_flying_d (w_flying_d),
        .o_launch_d (w_launch_d)
    );

    // Next-state logic; a hit outranks the target leaving the screen.
    always_comb begin
        w_state_d = ST_START;
        case (r_state)
            ST_START:    w_state_d = ST_PLAY;
            ST_PLAY: begin
                if (w_hit) begin
                    w_state_d = ST_WON;
                end else if (!i_sprite_target_within_screen) begin
                    w_state_d = ST_LOST;
                end else begin
                    w_state_d = ST_PLAY;
                end
            end
            ST_WON:      w_state_d = ST_WON_END;
            ST_WON_END:  w_state_d = i_end_of_game_timer_running ? ST_WON_END : ST_START;
            ST_LOST:     w_state_d = ST_LOST_END;
            ST_LOST_END: begin
                if (i_end_of_game_timer_running) begin
                    w_state_d = ST_LOST_END;
                end else if (r_lives == '0) begin
                    w_state_d = ST_OVER;
                end else begin
                    w_state_d = ST_START;
                end
            end
            ST_OVER:     w_state_d = w_fire ? ST_START : ST_OVER;
            default:     w_state_d = ST_START;
        endcase
    end

    // Output values for the next cycle, decoded from the next state and slot flags.
    always_comb begin
        w_ctrl_d = f_ctrl_decode(w_state_d);
        if (w_state_d == ST_START) begin
            w_torp_write_d = '1;
            w_torp_en_d    = '0;
        end else if (w_state_d == ST_PLAY) begin
            w_torp_write_d = w_launch_d;
            w_torp_en_d    = w_flying_d;
        end else begin
            w_torp_write_d = '0;
            w_torp_en_d    = '0;
        end
    end

    // Game FSM: state, key history, score, lives and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_START;
            r_key_q         <= 1'b0;
            r_score         <= '0;
            r_lives         <= LIVES_W'(LIVES);
            r_tgt_write_xy  <= 1'b1;
            r_tgt_write_dxy <= 1'b1;
            r_tgt_enable    <= 1'b0;
            r_torp_write    <= '1;
            r_torp_en       <= '0;
            r_timer_start   <= 1'b0;
            r_won           <= 1'b0;
            r_over          <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_key_q         <= i_key;
            r_tgt_write_xy  <= w_ctrl_d.tgt_write_xy;
            r_tgt_write_dxy <= w_ctrl_d.tgt_write_dxy;
            r_tgt_enable    <= w_ctrl_d.tgt_enable;
            r_torp_write    <= w_torp_write_d;
            r_torp_en       <= w_torp_en_d;
            r_timer_start   <= w_ctrl_d.timer_start;
            r_won           <= w_ctrl_d.won;
            r_over          <= w_ctrl_d.over;
            case (r_state)
                ST_WON: begin
                    if (r_score != '1) begin
                        r_score <= r_score + SCORE_W'(1);
                    end
                end
                ST_LOST: begin
                    if (r_lives != '0) begin
                        r_lives <= r_lives - LIVES_W'(1);
                    end
                end
                ST_OVER: begin
                    if (w_fire) begin
                        r_score <= '0;
                        r_lives <= LIVES_W'(LIVES);
                    end
                end
                default: begin
                    r_score <= r_score;
                end
            endcase
        end
    end

    assign o_sprite_target_write_xy       = r_tgt_write_xy;
    assign o_sprite_target_write_dxy      = r_tgt_write_dxy;
    assign o_sprite_target_enable_update  = r_tgt_enable;
    assign o_sprite_torpedo_write_xy      = r_torp_write;
    assign o_sprite_torpedo_write_dxy     = r_torp_write;
    assign o_sprite_torpedo_enable_update = r_torp_en;
    assign o_end_of_game_timer_start      = r_timer_start;
    assign o_game_won                     = r_won;
    assign o_game_over                    = r_over;
    assign o_score                        = r_score;
    assign o_lives_left                   = r_lives;

endmodule
